// File: rtl/collision_event_if.sv
// Bundle between the object renderers / game_controller and collision_event_generator.
// COLLISION_COUNT_EN adds the collisionCount bus.
interface collision_event_if;
    logic       startOfFrame;
    logic       pause;
    logic       drawingRequestSmiley;
    logic       drawingRequestBorderBottom;
    logic       drawingRequestObstacle;
    logic       obstacleIsReal;
    logic       collisionSmileyBorderBottom;
    logic       collisionSmileyObstacle;
    logic       collisionSmileyObstacleReal;
`ifdef COLLISION_COUNT_EN
    logic [7:0] collisionCount;

    modport master (
        output startOfFrame, pause, drawingRequestSmiley, drawingRequestBorderBottom,
               drawingRequestObstacle, obstacleIsReal,
        input  collisionSmileyBorderBottom, collisionSmileyObstacle,
               collisionSmileyObstacleReal, collisionCount
    );
    modport slave (
        input  startOfFrame, pause, drawingRequestSmiley, drawingRequestBorderBottom,
               drawingRequestObstacle, obstacleIsReal,
        output collisionSmileyBorderBottom, collisionSmileyObstacle,
               collisionSmileyObstacleReal, collisionCount
    );
`else
    modport master (
        output startOfFrame, pause, drawingRequestSmiley, drawingRequestBorderBottom,
               drawingRequestObstacle, obstacleIsReal,
        input  collisionSmileyBorderBottom, collisionSmileyObstacle,
               collisionSmileyObstacleReal
    );
    modport slave (
        input  startOfFrame, pause, drawingRequestSmiley, drawingRequestBorderBottom,
               drawingRequestObstacle, obstacleIsReal,
        output collisionSmileyBorderBottom, collisionSmileyObstacle,
               collisionSmileyObstacleReal
    );
`endif
endinterface

// File: rtl/collision_event_generator.sv
// Latches smiley collisions over a frame and emits one-cycle event pulses after startOfFrame.
// Optional COLLISION_COUNT_EN adds a saturating count of real-obstacle pulses.
module collision_event_generator #(
    parameter int HOLDOFF_FRAMES = 4,
    parameter int HOLD_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    collision_event_if.slave bus
);
    typedef enum logic {ST_ACCUM, ST_EMIT} state_t;

    state_t              state_q, state_d;
    logic                fb_q, fb_d, fo_q, fo_d, fr_q, fr_d;
    logic                outb_q, outb_d, outo_q, outo_d, outr_q, outr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                armed_q, armed_d;
    logic                hit_b, hit_o, hit_r, obs_mask;
    logic                set_b, set_o, set_r;
`ifdef COLLISION_COUNT_EN
    logic [7:0]          cnt_q, cnt_d;
`endif

    always_comb begin
        hit_b = bus.drawingRequestSmiley & bus.drawingRequestBorderBottom;
        hit_o = bus.drawingRequestSmiley & bus.drawingRequestObstacle;
        hit_r = hit_o & bus.obstacleIsReal;
        // The counter is only loaded at the end of the emit cycle, so mask that cycle explicitly.
        obs_mask = (hold_q != '0) ||
                   (state_q == ST_EMIT && outo_q && HOLDOFF_FRAMES != 0);
        set_b = hit_b;
        set_o = hit_o & ~obs_mask;
        set_r = hit_r & ~obs_mask;
    end

    always_comb begin
        state_d = state_q;
        fb_d    = fb_q | set_b;
        fo_d    = fo_q | set_o;
        fr_d    = fr_q | set_r;
        outb_d  = 1'b0;
        outo_d  = 1'b0;
        outr_d  = 1'b0;
        hold_d  = hold_q;
        armed_d = armed_q;
`ifdef COLLISION_COUNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_ACCUM: begin
                if (bus.startOfFrame) begin
                    state_d = ST_EMIT;
                    armed_d = 1'b1;
                    // Hits in the startOfFrame cycle belong to the frame just starting.
                    fb_d    = set_b;
                    fo_d    = set_o;
                    fr_d    = set_r;
                    // First frame after reset is partial; border hit wins over obstacles.
                    if (armed_q && !bus.pause) begin
                        outb_d = fb_q;
                        outo_d = fo_q & ~fb_q;
                        outr_d = fr_q & ~fb_q;
                    end
                    if (!bus.pause && hold_q != '0)
                        hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_EMIT: begin
                state_d = ST_ACCUM;
                if (outo_q && !bus.pause)
                    hold_d = HOLD_W'(HOLDOFF_FRAMES);
`ifdef COLLISION_COUNT_EN
                if (outr_q && cnt_q != 8'hFF)
                    cnt_d = cnt_q + 8'd1;
`endif
            end
            default: state_d = ST_ACCUM;
        endcase
        if (bus.pause) begin
            fb_d = 1'b0;
            fo_d = 1'b0;
            fr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            fb_q    <= 1'b0;
            fo_q    <= 1'b0;
            fr_q    <= 1'b0;
            outb_q  <= 1'b0;
            outo_q  <= 1'b0;
            outr_q  <= 1'b0;
            hold_q  <= '0;
            armed_q <= 1'b0;
`ifdef COLLISION_COUNT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            fb_q    <= fb_d;
            fo_q    <= fo_d;
            fr_q    <= fr_d;
            outb_q  <= outb_d;
            outo_q  <= outo_d;
            outr_q  <= outr_d;
            hold_q  <= hold_d;
            armed_q <= armed_d;
`ifdef COLLISION_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.collisionSmileyBorderBottom = outb_q;
    assign bus.collisionSmileyObstacle     = outo_q;
    assign bus.collisionSmileyObstacleReal = outr_q;
`ifdef COLLISION_COUNT_EN
    assign bus.collisionCount              = cnt_q;
`endif
endmodule
